act_relu_pipe: RTL and testbench
================================

Name: act_relu_pipe

Overview:
- Multi-lane, pipelined floating-point activation unit. It is the parametrised successor of the single-lane combinational ReLU.
- Sits between each neuron layer's accumulator output and the next layer's input buffer.
- Applies one of four per-beat selectable activations to LANES IEEE-754-style values, using a valid/ready handshake.
- Keeps a saturating count of zeroed outputs for sparsity monitoring.

Parameters:
- LANES, 4, number of parallel values per beat.
- EXP_W, 8, exponent width.
- MAN_W, 23, mantissa width. Element width DW = 1+EXP_W+MAN_W; defaults give FP32.
- LEAK_SHIFT, 3, leaky slope is 2^-LEAK_SHIFT, range 1..(2^EXP_W-2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_data  in  LANES*DW  lane k occupies bits [k*DW +: DW].
- in_mode  in  2  00 ReLU, 01 leaky ReLU, 10 clipped ReLU, 11 passthrough; sampled with the beat.
- clip_val  in  DW  positive upper bound for mode 10; quasi-static, sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*DW  results, same lane packing as in_data.
- zero_cnt  out  32  saturating count of +0 output lanes.
- zero_cnt_clr  in  1  synchronous clear of zero_cnt.

Behaviour:

Pipeline and handshake:
- Two register stages: S1 holds the captured beat and lane classification; S2 holds the result.
- Latency is exactly 2 cycles from accept (in_valid & in_ready) to out_valid when out_ready stays high.
- Throughput is 1 beat/cycle.
- Enables: en2 = ~s2_v | out_ready; en1 = ~s1_v | en2; in_ready = en1. in_ready is combinational from out_ready.
- While out_valid & ~out_ready, out_data and out_valid hold stable. No beat is dropped or duplicated.
- Mode and clip_val travel with their beat. A mode change between beats takes effect on the next accepted beat only.

Reset:
- s1_v = s2_v = 0, out_valid = 0, out_data = 0, zero_cnt = 0.
- in_ready goes 1 in the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats.

Lane classification (per lane, field views s/e/m):
- zero/denormal: e == 0. Flush to +0 in modes 00/01/10.
- inf: e all-ones, m == 0.
- NaN: e all-ones, m != 0. Output is the canonical qNaN {0, all-ones, 1, 0...} (FP32: 0x7FC00000) in modes 00/01/10.

Mode rules:
- 00 ReLU: s == 1 gives +0, including -0 and -inf. Otherwise output = input, +inf passes.
- 01 leaky ReLU:
  - Non-negative input follows the ReLU rule.
  - Negative normal input: if e > LEAK_SHIFT, output {1, e-LEAK_SHIFT, m}; otherwise +0 (underflow flush, no denormals produced).
  - -inf gives -inf.
- 10 clipped ReLU:
  - Apply ReLU first.
  - If the result's {e,m}, compared as unsigned, exceeds clip_val[DW-2:0], output clip_val with sign forced 0. +inf clips.
  - A clip_val with sign=1 or NaN is treated as +0, so every lane outputs +0.
- 11 passthrough: bit-exact copy with no flushing; NaN payloads are preserved.

zero_cnt:
- On each output transfer (out_valid & out_ready), add the number of lanes equal to all-zero (+0).
- Saturates at 0xFFFFFFFF.
- zero_cnt_clr has priority: if clear and a transfer occur in the same cycle, the result is 0.
- Counter updates are visible the cycle after the transfer.

Test Plan:
- Mode 00, FP32, LANES=4, lanes {0xC0000000, 0x40000000, 0x3E70068E, 0x80000000}, out_ready=1 -> 2 cycles later {0x00000000, 0x40000000, 0x3E70068E, 0x00000000}; zero_cnt=2 after transfer.
- Mode 01, LEAK_SHIFT=3, lanes {0xC0000000, 0x81800000, 0xFF800000, 0x3F800000} -> {0xBE800000, 0x00000000, 0xFF800000, 0x3F800000}.
- Mode 10, clip_val=0x40C00000, lanes {0x40F00000, 0x7F800000, 0x3E70068E, 0xBF800000} -> {0x40C00000, 0x40C00000, 0x3E70068E, 0x00000000}.
- NaN and denormal, lanes {0x7FC00001, 0x00000001, ...}:
  - Mode 00 -> {0x7FC00000, 0x00000000, ...}.
  - Mode 11 -> bit-exact copy.
- Backpressure:
  - Stream 6 beats with alternating modes while out_ready toggles 1,0,0,1,...
  - Required: outputs in order with correct per-beat mode; out_data stable while stalled; in_ready=0 once both stages are full and stalled.
- Counter and reset:
  - Preload zero_cnt near 0xFFFFFFFE, then send 4 zero lanes -> zero_cnt=0xFFFFFFFF.
  - Assert zero_cnt_clr together with a transfer -> 0.
  - Assert rst with 2 beats in flight -> out_valid=0 next cycle and no stale beat emerges.

Source files
------------

// File: rtl/act_relu_pipe.sv
// ============================================================================
// Module   : act_relu_pipe
// Brief    : Multi-lane two-stage FP activation unit (ReLU / leaky / clipped /
//            passthrough) with valid/ready handshake and zero-lane counter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module act_relu_pipe #(
    parameter int          LANES        = 4,
    parameter int          EXP_W        = 8,
    parameter int          MAN_W        = 23,
    parameter int          LEAK_SHIFT   = 3,
    parameter logic [31:0] ZERO_CNT_RST = 32'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_data,
    input  logic [1:0]                     in_mode,
    input  logic [EXP_W+MAN_W:0]           clip_val,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_data,
    output logic [31:0]                    zero_cnt,
    input  logic                           zero_cnt_clr
);

    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int CW = $clog2(LANES + 1);

    localparam logic [1:0] MODE_RELU  = 2'b00;
    localparam logic [1:0] MODE_LEAKY = 2'b01;
    localparam logic [1:0] MODE_CLIP  = 2'b10;

    localparam logic [DW-1:0]    QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] LEAK_E = EXP_W'(LEAK_SHIFT);

    // ------------------------------------------------------------------
    // Handshake enables
    // ------------------------------------------------------------------
    logic en1, en2;
    logic s1_v_q, s1_v_d;
    logic s2_v_q, s2_v_d;

    assign en2      = ~s2_v_q | out_ready;
    assign en1      = ~s1_v_q | en2;
    assign in_ready = en1;

    // ------------------------------------------------------------------
    // Stage-0 lane classification
    // ------------------------------------------------------------------
    logic [LANES-1:0] lane_zero, lane_inf, lane_nan;
    logic             clip_bad;

    always_comb begin
        lane_zero = '0;
        lane_inf  = '0;
        lane_nan  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_zero[k] = (in_data[k*DW+MAN_W +: EXP_W] == '0);
            lane_inf[k]  = (&in_data[k*DW+MAN_W +: EXP_W]) && (in_data[k*DW +: MAN_W] == '0);
            lane_nan[k]  = (&in_data[k*DW+MAN_W +: EXP_W]) && (in_data[k*DW +: MAN_W] != '0);
        end
        // Negative or NaN bound collapses to +0, forcing every clipped lane to +0
        clip_bad = clip_val[DW-1] | ((&clip_val[DW-2:MAN_W]) & (|clip_val[MAN_W-1:0]));
    end

    // ------------------------------------------------------------------
    // Stage 1: captured beat, mode, bound and classification
    // ------------------------------------------------------------------
    logic [LANES*DW-1:0] s1_data_q, s1_data_d;
    logic [1:0]          s1_mode_q, s1_mode_d;
    logic [DW-2:0]       s1_clip_q, s1_clip_d;
    logic                s1_clip_bad_q, s1_clip_bad_d;
    logic [LANES-1:0]    s1_zero_q, s1_zero_d;
    logic [LANES-1:0]    s1_inf_q, s1_inf_d;
    logic [LANES-1:0]    s1_nan_q, s1_nan_d;

    always_comb begin
        s1_v_d        = s1_v_q;
        s1_data_d     = s1_data_q;
        s1_mode_d     = s1_mode_q;
        s1_clip_d     = s1_clip_q;
        s1_clip_bad_d = s1_clip_bad_q;
        s1_zero_d     = s1_zero_q;
        s1_inf_d      = s1_inf_q;
        s1_nan_d      = s1_nan_q;
        if (en1) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_data_d     = in_data;
                s1_mode_d     = in_mode;
                s1_clip_d     = clip_val[DW-2:0];
                s1_clip_bad_d = clip_bad;
                s1_zero_d     = lane_zero;
                s1_inf_d      = lane_inf;
                s1_nan_d      = lane_nan;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-lane activation
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] act_lane(
        input logic [DW-1:0] x,
        input logic [1:0]    mode,
        input logic          is_zero,
        input logic          is_inf,
        input logic          is_nan,
        input logic [DW-2:0] clip_mag,
        input logic          bad_clip
    );
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic [DW-1:0]    relu;
        logic [DW-1:0]    r;
        s    = x[DW-1];
        e    = x[DW-2:MAN_W];
        m    = x[MAN_W-1:0];
        relu = (s || is_zero) ? '0 : x;
        r    = x;
        case (mode)
            MODE_RELU:  r = is_nan ? QNAN : relu;
            MODE_LEAKY: begin
                if (is_nan)              r = QNAN;
                else if (!s || is_zero)  r = relu;
                else if (is_inf)         r = x;
                else if (e > LEAK_E)     r = {1'b1, e - LEAK_E, m};
                else                     r = '0;
            end
            MODE_CLIP: begin
                if (bad_clip)                      r = '0;
                else if (is_nan)                   r = QNAN;
                else if (relu[DW-2:0] > clip_mag)  r = {1'b0, clip_mag};
                else                               r = relu;
            end
            default:    r = x;
        endcase
        return r;
    endfunction

    logic [LANES*DW-1:0] s1_result;

    always_comb begin
        s1_result = '0;
        for (int k = 0; k < LANES; k++) begin
            s1_result[k*DW +: DW] = act_lane(s1_data_q[k*DW +: DW], s1_mode_q,
                                             s1_zero_q[k], s1_inf_q[k], s1_nan_q[k],
                                             s1_clip_q, s1_clip_bad_q);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: result register
    // ------------------------------------------------------------------
    logic [LANES*DW-1:0] out_data_q, out_data_d;

    always_comb begin
        s2_v_d     = s2_v_q;
        out_data_d = out_data_q;
        if (en2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                out_data_d = s1_result;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = out_data_q;

    // ------------------------------------------------------------------
    // Saturating +0 lane counter
    // ------------------------------------------------------------------
    logic [31:0]   zero_cnt_q, zero_cnt_d;
    logic [CW-1:0] zero_lanes;
    logic [32:0]   zero_sum;

    always_comb begin
        zero_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            if (out_data_q[k*DW +: DW] == '0) begin
                zero_lanes = zero_lanes + CW'(1);
            end
        end
        zero_sum   = {1'b0, zero_cnt_q} + {{(33-CW){1'b0}}, zero_lanes};
        zero_cnt_d = zero_cnt_q;
        if (zero_cnt_clr) begin
            zero_cnt_d = '0;
        end else if (s2_v_q && out_ready) begin
            zero_cnt_d = zero_sum[32] ? 32'hFFFF_FFFF : zero_sum[31:0];
        end
    end

    assign zero_cnt = zero_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q        <= 1'b0;
            s1_data_q     <= '0;
            s1_mode_q     <= '0;
            s1_clip_q     <= '0;
            s1_clip_bad_q <= 1'b0;
            s1_zero_q     <= '0;
            s1_inf_q      <= '0;
            s1_nan_q      <= '0;
            s2_v_q        <= 1'b0;
            out_data_q    <= '0;
            zero_cnt_q    <= ZERO_CNT_RST;
        end else begin
            s1_v_q        <= s1_v_d;
            s1_data_q     <= s1_data_d;
            s1_mode_q     <= s1_mode_d;
            s1_clip_q     <= s1_clip_d;
            s1_clip_bad_q <= s1_clip_bad_d;
            s1_zero_q     <= s1_zero_d;
            s1_inf_q      <= s1_inf_d;
            s1_nan_q      <= s1_nan_d;
            s2_v_q        <= s2_v_d;
            out_data_q    <= out_data_d;
            zero_cnt_q    <= zero_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_act_relu_pipe.sv
// ============================================================================
// Module   : tb_act_relu_pipe
// Brief    : Directed self-checking bench for act_relu_pipe (FP32, 4 lanes).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_act_relu_pipe;

    localparam int VW = 128;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, zero_cnt_clr;
    logic [1:0]    in_mode;
    logic [VW-1:0] in_data;
    logic [31:0]   clip_val;
    logic          in_ready, out_valid;
    logic [VW-1:0] out_data;
    logic [31:0]   zero_cnt;
    logic          sat_in_ready, sat_out_valid;
    logic [VW-1:0] sat_out_data;
    logic [31:0]   sat_zero_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_zc;

    always #5 clk = ~clk;

    act_relu_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .clip_val(clip_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .zero_cnt(zero_cnt), .zero_cnt_clr(zero_cnt_clr)
    );

    // Second instance starts its counter near saturation
    act_relu_pipe #(.ZERO_CNT_RST(32'hFFFF_FFFE)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_data(in_data), .in_mode(in_mode), .clip_val(clip_val),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .zero_cnt(sat_zero_cnt), .zero_cnt_clr(zero_cnt_clr)
    );

    task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                            input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] nz(input logic [VW-1:0] v);
        logic [31:0] n;
        n = 0;
        for (int k = 0; k < 4; k++) if (v[k*32 +: 32] == 32'h0) n = n + 1;
        return n;
    endfunction

    task automatic run_beat(input string tag, input logic [VW-1:0] d, input logic [1:0] md,
                            input logic [31:0] cv, input logic [VW-1:0] exp, input logic clr);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_mode = md; clip_val = cv;
        @(negedge clk);
        check({tag, "_rdy"}, VW'(in_ready), VW'(1));
        @(posedge clk); #1;
        // Scramble the inputs so a late sample of mode/bound/data shows up
        in_valid = 1'b0; in_data = '1; in_mode = ~md; clip_val = 32'hFFFF_FFFF;
        @(negedge clk);
        check({tag, "_v1"}, VW'(out_valid), VW'(0));
        @(posedge clk); #1;
        zero_cnt_clr = clr;
        @(negedge clk);
        check({tag, "_v2"}, VW'(out_valid), VW'(1));
        check({tag, "_data"}, out_data, exp);
        @(posedge clk); #1;
        zero_cnt_clr = 1'b0;
        exp_zc = clr ? 32'h0 : exp_zc + nz(exp);
        @(negedge clk);
        check({tag, "_zc"}, VW'(zero_cnt), VW'(exp_zc));
    endtask

    logic [VW-1:0] bp_d [6];
    logic [1:0]    bp_m [6];
    logic [31:0]   bp_c [6];
    logic [VW-1:0] bp_e [6];
    logic [VW-1:0] bp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            bi, pops, occ, stall_seen;
        logic          hold;
        logic [VW-1:0] hold_data, stim;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; zero_cnt_clr = 1'b0;
        in_mode = 2'b00; in_data = '0; clip_val = '0; exp_zc = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_out_data", out_data, VW'(0));
        check("rst_zero_cnt", VW'(zero_cnt), VW'(0));
        check("rst_sat_cnt", VW'(sat_zero_cnt), VW'(32'hFFFF_FFFE));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", VW'(in_ready), VW'(1));

        run_beat("sat4", pack4(32'h0, 32'h8000_0000, 32'h0000_0001, 32'hBF80_0000), 2'b00, 32'h0,
                 pack4(32'h0, 32'h0, 32'h0, 32'h0), 1'b0);
        check("sat_cnt", VW'(sat_zero_cnt), VW'(32'hFFFF_FFFF));

        run_beat("relu", pack4(32'hC000_0000, 32'h4000_0000, 32'h3E70_068E, 32'h8000_0000), 2'b00, 32'h0,
                 pack4(32'h0, 32'h4000_0000, 32'h3E70_068E, 32'h0), 1'b0);
        run_beat("leaky", pack4(32'hC000_0000, 32'h8180_0000, 32'hFF80_0000, 32'h3F80_0000), 2'b01, 32'h0,
                 pack4(32'hBE80_0000, 32'h0, 32'hFF80_0000, 32'h3F80_0000), 1'b0);
        run_beat("clip", pack4(32'h40F0_0000, 32'h7F80_0000, 32'h3E70_068E, 32'hBF80_0000), 2'b10, 32'h40C0_0000,
                 pack4(32'h40C0_0000, 32'h40C0_0000, 32'h3E70_068E, 32'h0), 1'b0);
        run_beat("clip_bad", pack4(32'h4000_0000, 32'h3F80_0000, 32'h0, 32'h7F80_0000), 2'b10, 32'hC000_0000,
                 pack4(32'h0, 32'h0, 32'h0, 32'h0), 1'b0);
        run_beat("nan_relu", pack4(32'h7FC0_0001, 32'h0000_0001, 32'h8000_0001, 32'h3F80_0000), 2'b00, 32'h0,
                 pack4(32'h7FC0_0000, 32'h0, 32'h0, 32'h3F80_0000), 1'b0);
        run_beat("nan_pass", pack4(32'h7FC0_0001, 32'h0000_0001, 32'h8000_0001, 32'h3F80_0000), 2'b11, 32'h0,
                 pack4(32'h7FC0_0001, 32'h0000_0001, 32'h8000_0001, 32'h3F80_0000), 1'b0);

        // Backpressure stream: same lanes, modes rotate, out_ready pattern 1,0,0
        stim = pack4(32'hC000_0000, 32'h4000_0000, 32'h7FC0_0001, 32'h0000_0001);
        for (int i = 0; i < 6; i++) begin
            bp_d[i] = stim;
            bp_m[i] = 2'(i % 4);
            bp_c[i] = 32'h3F80_0000;
        end
        bp_e[0] = pack4(32'h0, 32'h4000_0000, 32'h7FC0_0000, 32'h0);
        bp_e[1] = pack4(32'hBE80_0000, 32'h4000_0000, 32'h7FC0_0000, 32'h0);
        bp_e[2] = pack4(32'h0, 32'h3F80_0000, 32'h7FC0_0000, 32'h0);
        bp_e[3] = stim;
        bp_e[4] = bp_e[0];
        bp_e[5] = bp_e[1];

        bi = 0; pops = 0; occ = 0; stall_seen = 0; hold = 1'b0; hold_data = '0;
        for (int cyc = 0; cyc < 200 && pops < 6; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc % 3 == 0);
            if (bi < 6) begin
                in_valid = 1'b1; in_data = bp_d[bi]; in_mode = bp_m[bi]; clip_val = bp_c[bi];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_in_ready", VW'(in_ready), VW'((occ < 2) || out_ready));
            if (occ == 2 && !out_ready) stall_seen++;
            if (hold) begin
                check("bp_hold_valid", VW'(out_valid), VW'(1));
                check("bp_hold_data", out_data, hold_data);
            end
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                if (bp_q.size() > 0) begin
                    hold_data = bp_q.pop_front();
                    check("bp_data", out_data, hold_data);
                    exp_zc = exp_zc + nz(hold_data);
                end else begin
                    check("bp_extra_beat", VW'(1), VW'(0));
                end
                pops++;
                occ--;
            end
            if (in_valid && in_ready) begin
                bp_q.push_back(bp_e[bi]);
                bi++;
                occ++;
            end
        end
        check("bp_done", VW'(pops), VW'(6));
        check("bp_stall_seen", VW'(stall_seen > 0), VW'(1));
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("bp_zc", VW'(zero_cnt), VW'(exp_zc));

        run_beat("clr", pack4(32'h0, 32'h0, 32'h4000_0000, 32'h8000_0000), 2'b00, 32'h0,
                 pack4(32'h0, 32'h0, 32'h4000_0000, 32'h0), 1'b1);
        check("clr_sat_cnt", VW'(sat_zero_cnt), VW'(0));

        // Reset with two beats in flight
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = stim; in_mode = 2'b00;
        @(posedge clk); #1;
        in_mode = 2'b11;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rrst_valid", VW'(out_valid), VW'(0));
        check("rrst_zc", VW'(zero_cnt), VW'(0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rrst_no_stale", VW'(out_valid), VW'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
